// File: rtl/fft_to_ram.sv
// fft_to_ram -- write side of the shared waterfall memory.
//
// Takes the FFT magnitude stream one bin per beat, keeps the lower half of
// each frame (bins 0..FFT_SIZE/2-1), quantises every kept bin to a PIX_W
// pixel and writes it into a circular buffer of NO_FFTS rows spread over
// NO_BANKS RAM banks. The mirror half of the frame is accepted and dropped.
//
// Handshake: a beat transfers on a rising clk edge where s_valid and s_ready
// are both 1. s_valid may rise at any time and the producer holds s_data and
// s_last until the transfer. s_ready does not depend on s_valid. It is 0
// during reset and during the single commit cycle after a frame, and 1 at
// all other times.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   freeze           pause waterfall; sampled on the first beat of a frame
//   s_valid/s_ready  input handshake
//   s_data, s_last   bin magnitude, marks bin FFT_SIZE-1
//   wr_en            RAM write strobe (1 cycle after the accepted beat)
//   wr_bank_select   one-hot bank, from the row index MSB
//   wr_address       {row[IDXW-2:0], bin[BINW-1:0]}
//   wr_data          pixel
//   oldest_fft_idx   next row to be overwritten (top of display)
//   frame_done       1-cycle pulse per committed row
//   frame_err        sticky malformed-frame flag, cleared by reset only
//
// Configuration macro: LOG_COMPRESS_EN selects a log2 pixel mapping
// (floor(log2(s_data)), saturated) instead of the linear shift-and-saturate.
module fft_to_ram #(
    parameter int NO_BANKS       = 2,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int NO_FFTS        = 50,
    parameter int FFT_SIZE       = 256,
    parameter int DATA_W         = 16,
    parameter int PIX_W          = 4,
    parameter int SHIFT          = 8,
    localparam int IDXW          = $clog2(NO_FFTS),
    localparam int BINW          = $clog2(FFT_SIZE / 2),
    localparam int CNTW          = $clog2(FFT_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      freeze,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      s_last,
    output logic                      wr_en,
    output logic [NO_BANKS-1:0]       wr_bank_select,
    output logic [RAM_ADDR_WIDTH-1:0] wr_address,
    output logic [PIX_W-1:0]          wr_data,
    output logic [IDXW-1:0]           oldest_fft_idx,
    output logic                      frame_done,
    output logic                      frame_err
);

    localparam logic [CNTW-1:0] HALF_LAST  = CNTW'(FFT_SIZE / 2 - 1);
    localparam logic [CNTW-1:0] FRAME_LAST = CNTW'(FFT_SIZE - 1);
    localparam logic [IDXW-1:0] ROW_LAST   = IDXW'(NO_FFTS - 1);

    typedef enum logic [1:0] {S_LOW, S_MIRROR, S_COMMIT, S_DROP} state_t;

    state_t          state, state_nx;
    logic [CNTW-1:0] bin_cnt, cnt_nx;
    logic [IDXW-1:0] wr_row;
    logic            ready_q;
    logic            frozen_q;
    logic            err_set;
    logic            accept;
    logic            frame_frozen;
    logic            wr_fire;
    logic            commit;
    logic [PIX_W-1:0] pix;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_LOW;
            bin_cnt <= '0;
        end else begin
            state   <= state_nx;
            bin_cnt <= cnt_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        cnt_nx   = bin_cnt;
        err_set  = 1'b0;
        case (state)
            S_LOW: begin
                if (accept) begin
                    if (s_last) begin
                        // Early s_last still ends the frame; the row is not committed.
                        err_set = 1'b1;
                        cnt_nx  = '0;
                    end else begin
                        cnt_nx = bin_cnt + 1'b1;
                        if (bin_cnt == HALF_LAST) state_nx = S_MIRROR;
                    end
                end
            end
            S_MIRROR: begin
                if (accept) begin
                    if (s_last) begin
                        cnt_nx = '0;
                        if (bin_cnt == FRAME_LAST) begin
                            state_nx = S_COMMIT;
                        end else begin
                            err_set  = 1'b1;
                            state_nx = S_LOW;
                        end
                    end else if (bin_cnt == FRAME_LAST) begin
                        // Frame too long: swallow beats until the producer's s_last.
                        err_set  = 1'b1;
                        state_nx = S_DROP;
                    end else begin
                        cnt_nx = bin_cnt + 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                state_nx = S_LOW;
                cnt_nx   = '0;
            end
            S_DROP: begin
                if (accept && s_last) begin
                    state_nx = S_LOW;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_LOW;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        s_ready      = ready_q && (state != S_COMMIT);
        accept       = s_valid && s_ready;
        // Bin 0 uses the live freeze input; later bins use the value latched there.
        frame_frozen = (bin_cnt == '0) ? freeze : frozen_q;
        wr_fire      = accept && (state == S_LOW) && !frame_frozen;
        commit       = (state == S_COMMIT) && !frozen_q;
    end

    // Pixel quantisation
`ifdef LOG_COMPRESS_EN
    always_comb begin
        pix = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (s_data[i]) pix = (i > (2 ** PIX_W) - 1) ? '1 : PIX_W'(i);
        end
    end
`else
    logic [DATA_W-1:0] q;
    always_comb begin
        q   = s_data >> SHIFT;
        pix = (q > DATA_W'((2 ** PIX_W) - 1)) ? '1 : q[PIX_W-1:0];
    end
`endif

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q        <= 1'b0;
            frozen_q       <= 1'b0;
            wr_row         <= '0;
            wr_en          <= 1'b0;
            wr_bank_select <= '0;
            wr_address     <= '0;
            wr_data        <= '0;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            wr_en      <= wr_fire;
            frame_done <= commit;
            if (accept && (state == S_LOW) && (bin_cnt == '0)) frozen_q <= freeze;
            if (wr_fire) begin
                wr_bank_select <= NO_BANKS'(1) << wr_row[IDXW-1];
                wr_address     <= RAM_ADDR_WIDTH'({wr_row[IDXW-2:0], bin_cnt[BINW-1:0]});
                wr_data        <= pix;
            end
            if (commit) wr_row <= (wr_row == ROW_LAST) ? '0 : wr_row + 1'b1;
            if (err_set) frame_err <= 1'b1;
        end
    end

    // The oldest row on display is always the next one to be overwritten.
    assign oldest_fft_idx = wr_row;

endmodule

// File: tb/tb_fft_to_ram.sv
// Testbench for fft_to_ram: directed frames with a scoreboard of expected
// RAM writes, a quantisation vector table, and hand-written error, freeze
// and reset sequences.
module tb_fft_to_ram;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        wr_en;
    logic [1:0]  wr_bank_select;
    logic [11:0] wr_address;
    logic [3:0]  wr_data;
    logic [5:0]  oldest_fft_idx;
    logic        frame_done;
    logic        frame_err;

    fft_to_ram dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .freeze         (freeze),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .wr_en          (wr_en),
        .wr_bank_select (wr_bank_select),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .oldest_fft_idx (oldest_fft_idx),
        .frame_done     (frame_done),
        .frame_err      (frame_err)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int done_snap = 0;
    logic [17:0] exp_q[$];
    logic [17:0] act_q[$];
    logic [15:0] data_arr [256];
    logic [5:0]  model_row = '0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  exp_lin;
        logic [3:0]  exp_log;
    } qvec_t;
    qvec_t qtab [12];

    // Monitor: capture writes and frame_done pulses away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) act_q.push_back({wr_bank_select, wr_address, wr_data});
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference pixel mapping, written independently of the RTL structure.
    function automatic logic [3:0] pix_model(input logic [15:0] d);
        logic [3:0] r;
        r = 4'd0;
`ifdef LOG_COMPRESS_EN
        for (int i = 0; i < 16; i++) if (d[i]) r = 4'(i);
`else
        r = (d >= 16'h1000) ? 4'hf : d[11:8];
`endif
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [15:0] d, input logic l, input logic frz, input bit gaps);
        int budget;
        if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        freeze  = frz;
        budget  = 0;
        while (!s_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!s_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, budget);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n_beats, input int last_pos, input bit frz, input bit gaps);
        logic [15:0] d;
        done_snap = done_cnt;
        for (int b = 0; b < n_beats; b++) begin
            d = (b < 256) ? data_arr[b] : 16'h1234;
            send_beat(d, (b == last_pos - 1), frz && (b < 10), gaps);
        end
        freeze = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    // Compare captured writes against the model row, then advance the model.
    task automatic check_frame(input string name, input int n_wr, input int commit);
        logic [17:0] e, a;
        logic [6:0]  bin;
        for (int i = 0; i < n_wr; i++) begin
            bin = 7'(i);
            exp_q.push_back({(model_row >= 6'd32) ? 2'b10 : 2'b01,
                             model_row[4:0], bin, pix_model(data_arr[i])});
        end
        check({name, ".write_count"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            check({name, ".write"}, a, e);
        end
        exp_q.delete();
        act_q.delete();
        check({name, ".frame_done"}, done_cnt - done_snap, commit);
        if (commit != 0) model_row = (model_row == 6'd49) ? 6'd0 : model_row + 6'd1;
        check({name, ".oldest"}, oldest_fft_idx, model_row);
        check({name, ".wr_en_idle"}, wr_en, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".s_ready"}, s_ready, 0);
        check({name, ".wr_en"}, wr_en, 0);
        check({name, ".bank"}, wr_bank_select, 0);
        check({name, ".addr"}, wr_address, 0);
        check({name, ".data"}, wr_data, 0);
        check({name, ".oldest"}, oldest_fft_idx, 0);
        check({name, ".frame_done"}, frame_done, 0);
        check({name, ".frame_err"}, frame_err, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        qtab[0]  = '{16'h0000, 4'd0,  4'd0};
        qtab[1]  = '{16'h0001, 4'd0,  4'd0};
        qtab[2]  = '{16'h0002, 4'd0,  4'd1};
        qtab[3]  = '{16'h0003, 4'd0,  4'd1};
        qtab[4]  = '{16'h8000, 4'd15, 4'd15};
        qtab[5]  = '{16'hFFFF, 4'd15, 4'd15};
        qtab[6]  = '{16'h00FF, 4'd0,  4'd7};
        qtab[7]  = '{16'h0100, 4'd1,  4'd8};
        qtab[8]  = '{16'h0500, 4'd5,  4'd10};
        qtab[9]  = '{16'h0A7F, 4'd10, 4'd11};
        qtab[10] = '{16'h0FFF, 4'd15, 4'd11};
        qtab[11] = '{16'h1000, 4'd15, 4'd12};

        for (int i = 0; i < 256; i++) data_arr[i] = 16'(i * 256);

        rst_n   = 1'b0;
        freeze  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;

        // Reset state
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset.s_ready", s_ready, 1);

        // One clean frame, then 50 more to fill and wrap the buffer
        send_frame(256, 256, 1'b0, 1'b0);
        check_frame("frame1", 128, 1);
        check("frame1.oldest_is_1", oldest_fft_idx, 1);
        for (int f = 2; f <= 51; f++) begin
            send_frame(256, 256, 1'b0, 1'b0);
            check_frame($sformatf("frame%0d", f), 128, 1);
            if (f == 50) check("frame50.oldest_wrap", oldest_fft_idx, 0);
        end
        check("clean.frame_err", frame_err, 0);

        // Frozen frame (freeze dropped at bin 10), then a clean frame with gaps
        send_frame(256, 256, 1'b1, 1'b0);
        check_frame("frozen", 0, 0);
        send_frame(256, 256, 1'b0, 1'b1);
        check_frame("gaps", 128, 1);
        check("gaps.frame_err", frame_err, 0);

        // Early s_last at beat 100: bins 0..99 land, nothing commits
        send_frame(100, 100, 1'b0, 1'b0);
        check_frame("early_last", 100, 0);
        check("early_last.frame_err", frame_err, 1);
        send_frame(256, 256, 1'b0, 1'b0);
        check_frame("after_early", 128, 1);

        // Overlong frame: 300 beats, s_last only on the last
        send_frame(300, 300, 1'b0, 1'b0);
        check_frame("overlong", 128, 0);
        check("overlong.frame_err", frame_err, 1);
        send_frame(256, 256, 1'b0, 1'b1);
        check_frame("after_overlong", 128, 1);

        // Asynchronous reset mid-frame
        for (int b = 0; b < 40; b++) send_beat(data_arr[b], 1'b0, 1'b0, 1'b0);
        check("pre_reset.wr_en", wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        act_q.delete();
        model_row = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_reset.s_ready_after", s_ready, 1);

        // Quantisation vector table, carried in the first bins of a frame
        for (int i = 0; i < 12; i++) data_arr[i] = qtab[i].data;
        send_frame(256, 256, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (i < act_q.size()) begin
`ifdef LOG_COMPRESS_EN
                check($sformatf("qtab[%0d]", i), act_q[i][3:0], qtab[i].exp_log);
`else
                check($sformatf("qtab[%0d]", i), act_q[i][3:0], qtab[i].exp_lin);
`endif
            end else begin
                check($sformatf("qtab[%0d].present", i), act_q.size(), i + 1);
            end
        end
        check_frame("quant_frame", 128, 1);
        check("quant_frame.row_after_reset", oldest_fft_idx, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
